// File: rtl/mux41_rr_arbiter_pkg.sv
// Shared constants, state encoding and helpers for the round-robin mux arbiter.
package mux41_arb_pkg;

  localparam int unsigned N_REQ = 4;
  localparam int unsigned SEL_W = 2;

  typedef enum logic {
    ST_IDLE,
    ST_GRANT
  } state_t;

  function automatic logic [N_REQ-1:0] idx2onehot(input logic [SEL_W-1:0] idx);
    logic [N_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/mux41_rr_arbiter_if.sv
// Request/grant/select bundle between the requesters and the arbiter.
interface mux41_rr_arbiter_if
  import mux41_arb_pkg::*;
  ;
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] gnt;
  logic             s1;
  logic             s0;
  logic             busy;

  modport master (output req, input gnt, s1, s0, busy);
  modport slave  (input req, output gnt, s1, s0, busy);
endinterface

// File: rtl/mux41_rr_arbiter_rr_pick4.sv
// Combinational round-robin picker: first set mask bit at or after i_start, wrapping.
module rr_pick4
  import mux41_arb_pkg::*;
(
  input  logic [N_REQ-1:0] i_mask,
  input  logic [SEL_W-1:0] i_start,
  output logic             o_found,
  output logic [SEL_W-1:0] o_idx
);

  logic [SEL_W-1:0] w_cand;

  always_comb begin
    o_found = 1'b0;
    o_idx   = i_start;
    w_cand  = i_start;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      w_cand = i_start + SEL_W'(k);
      if (!o_found && i_mask[w_cand]) begin
        o_found = 1'b1;
        o_idx   = w_cand;
      end
    end
  end

endmodule

// File: rtl/mux41_rr_arbiter.sv
// Round-robin scheduler driving the select lines of a 4:1 mux (mux41_21).
// Define MUX41_ARB_TIMEOUT_EN to compile in the HOLD_MAX hold-limit rotation.
module mux41_rr_arbiter
  import mux41_arb_pkg::*;
#(
  parameter int unsigned HOLD_MAX = 8
) (
  input logic                clk,
  input logic                rst_n,
  mux41_rr_arbiter_if.slave  bus
);

  if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_hold_max_chk
    $error("HOLD_MAX must be within 1..255");
  end

  state_t           r_state, w_state_nxt;
  logic [SEL_W-1:0] r_sel, w_sel_nxt;
  logic [SEL_W-1:0] r_last, w_last_nxt;
  logic [N_REQ-1:0] r_gnt, w_gnt_nxt;
  logic [N_REQ-1:0] w_mask;
  logic             w_found;
  logic [SEL_W-1:0] w_pick;
  logic             w_new_grant;
  logic             w_hold_hit;

  // The holder is masked out so release and timeout both hand over to someone else.
  assign w_mask = bus.req & ~((r_state == ST_GRANT) ? idx2onehot(r_sel) : '0);

  rr_pick4 u_pick (
    .i_mask  (w_mask),
    .i_start (r_last + SEL_W'(1)),
    .o_found (w_found),
    .o_idx   (w_pick)
  );

`ifdef MUX41_ARB_TIMEOUT_EN
  logic [7:0] r_hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold <= '0;
    end else if (w_new_grant) begin
      r_hold <= '0;
    end else if (r_state == ST_GRANT && r_hold != 8'(HOLD_MAX)) begin
      r_hold <= r_hold + 8'd1;
    end
  end

  // r_hold counts completed cycles beyond the first, so H-1 means H cycles held.
  assign w_hold_hit = (r_hold >= 8'(HOLD_MAX - 1));
`else
  assign w_hold_hit = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_last_nxt  = r_last;
    w_gnt_nxt   = r_gnt;
    w_new_grant = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_found) w_new_grant = 1'b1;
      end
      ST_GRANT: begin
        if (!bus.req[r_sel]) begin
          if (w_found) begin
            w_new_grant = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
            w_gnt_nxt   = '0;
          end
        end else if (w_hold_hit && w_found) begin
          w_new_grant = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_gnt_nxt   = '0;
      end
    endcase
    if (w_new_grant) begin
      w_state_nxt = ST_GRANT;
      w_sel_nxt   = w_pick;
      w_last_nxt  = w_pick;
      w_gnt_nxt   = idx2onehot(w_pick);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_sel   <= '0;
      r_last  <= '1;
      r_gnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
      r_last  <= w_last_nxt;
      r_gnt   <= w_gnt_nxt;
    end
  end

  assign bus.gnt  = r_gnt;
  assign bus.s1   = r_sel[1];
  assign bus.s0   = r_sel[0];
  assign bus.busy = |r_gnt;

endmodule

// File: doc/mux41_rr_arbiter.md
# mux41_rr_arbiter

Round-robin arbiter that shares one 4:1 mux datapath among four requesters. It accepts a request vector and grants exactly one requester at a time. It drives the mux select lines so the granted input appears at the mux output, plus a one-hot grant back to the requesters. It sits directly in front of `mux41_21` and replaces static select wiring with a fair, registered scheduler.

## Interface
- `HOLD_MAX`, default 8: maximum consecutive cycles one requester may hold the grant while others wait. Legal range 1–255. Used only when the timeout feature is compiled in.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `req` input 4: request vector; bit k = requester k (mux input ik).
- `gnt` output 4: one-hot grant, registered; all-zero when idle.
- `s1` output 1: mux select MSB, registered.
- `s0` output 1: mux select LSB, registered.
- `busy` output 1: high whenever any `gnt` bit is high.

## Operation
- Two states:
  - IDLE: no grant.
  - GRANT: one holder `cur`.
- Round-robin pointer `last` (2 bits) = index of the most recently granted requester. The search order starts at (`last`+1) mod 4 and wraps through all four indices.
- IDLE:
  - If `req` ≠ 0, pick the first asserted bit in search order, set `cur`/`last` to it, and go to GRANT.
  - Else stay in IDLE.
- GRANT, evaluated each edge:
  - If `req[cur]` = 0 (release): pick the next requester in search order excluding `cur`. If one exists, grant it at this edge with no idle gap. Else go to IDLE.
  - If `req[cur]` = 1 and the hold limit is reached (feature on) and another request is pending: rotate to the next requester in search order.
  - Otherwise keep the grant.
- Hold counter:
  - Counts cycles of the current grant.
  - Cleared on every new grant.
  - Saturates at `HOLD_MAX`.
- Select encoding: {`s1`,`s0`} = `cur` (00→i0, 01→i1, 10→i2, 11→i3). The selects keep their last value in IDLE, so there is no glitching on the mux.
- A requester that drops and immediately re-raises `req` goes behind the others in rotation.
- `req` bits for non-holders may toggle freely; only sampled values at the edge matter.

## Timing
- Reset values: `gnt`=0000, `s1`=0, `s0`=0, `busy`=0, `last`=3 (first search starts at requester 0), hold count=0, state IDLE.
- Grant latency: `req` sampled high at edge N → `gnt`/selects valid after edge N (one cycle).
- Handover latency: holder drops `req` before edge N → the new `gnt` and selects are valid after edge N. `gnt` never has two bits set and is never zero between back-to-back grants.
- Timeout (feature on): with `HOLD_MAX`=H, a contended holder keeps `gnt` for exactly H cycles, then is rotated out.
- Uncontended holder is never rotated out.
- Reset asserted mid-grant: all outputs go to reset values immediately (asynchronously). Arbitration restarts from requester 0 after `rst_n` rises.
- Simultaneous release by the holder and new requests: resolved in the same edge per the search order.

## Configuration
- `MUX41_ARB_TIMEOUT_EN` defined: hold counter and `HOLD_MAX` limit are compiled in.
- `MUX41_ARB_TIMEOUT_EN` undefined: no counter logic. The holder keeps the grant until it drops `req`, and `HOLD_MAX` is ignored.

## Structure
- Package `mux41_arb_pkg`:
  - `N_REQ`=4.
  - State enum {ST_IDLE, ST_GRANT}.
  - Select width constant `SEL_W`=2.
- Sub-module `rr_pick4`: combinational picker. Inputs are the 4-bit request mask and the 2-bit start index; outputs are the found flag and the 2-bit index. It is instantiated once in the arbiter.

## Test plan
- Reset then `req`=0100 → after one edge `gnt`=0100, {`s1`,`s0`}=10, `busy`=1.
- `req`=1111 held, each holder releases after 2 cycles → grant order 0,1,2,3,0 with no idle cycle between grants.
- Timeout on, `HOLD_MAX`=3, `req`=0011 constant → `gnt` alternates 0001 for 3 cycles, then 0010 for 3 cycles, repeating. Timeout off → `gnt` stays 0001.
- Holder 2 releases while `req`=1001 → next grant is 3, then 0 (wrap-around).
- `rst_n` pulsed low during grant 2 → `gnt`=0000 and selects=00 immediately. After release with `req`=1100, first grant is 2.
- Connect to `mux41_21` with i0..i3=0,1,1,0 → output `y` equals the granted input every cycle.
